// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op-code constants,
// the result-register state encoding and the legal-op decode helper.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; any code outside the legal set yields zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_op,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLT:  o_result = (i_a < i_b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU and holds each result in a
// single output register until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_id,
  output logic              rsp_err
);

  state_t            r_state;
  logic              r_rrPtr;
  logic [DATA_W-1:0] r_rspData;
  logic              r_rspZero;
  logic              r_rspId;
  logic              r_rspErr;

  logic              w_canAccept;
  logic              w_grant;
  logic              w_xfer;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_result;

  // r_rrPtr names the requester favoured when both are valid at once.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid)
      w_grant = FIXED_PRI ? 1'b0 : r_rrPtr;
    else if (req1_valid)
      w_grant = 1'b1;
  end

  assign w_canAccept = (r_state == ST_EMPTY) || rsp_ready;
  assign req0_ready  = !reset && w_canAccept && req0_valid && !w_grant;
  assign req1_ready  = !reset && w_canAccept && req1_valid &&  w_grant;
  assign w_xfer      = req0_ready || req1_ready;

  assign w_a  = w_grant ? req1_a  : req0_a;
  assign w_b  = w_grant ? req1_b  : req0_b;
  assign w_op = w_grant ? req1_op : req0_op;

  alu_arbiter_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_result)
  );

  // A new transfer always wins over a drain, giving back-to-back results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_rrPtr   <= 1'b0;
      r_rspData <= '0;
      r_rspZero <= 1'b0;
      r_rspId   <= 1'b0;
      r_rspErr  <= 1'b0;
    end else if (w_xfer) begin
      r_state   <= ST_FULL;
      r_rrPtr   <= ~w_grant;
      r_rspData <= w_result;
      r_rspZero <= (w_result == '0);
      r_rspId   <= w_grant;
      r_rspErr  <= !isLegalOp(w_op);
    end else if ((r_state == ST_FULL) && rsp_ready) begin
      r_state   <= ST_EMPTY;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_rspData;
  assign rsp_zero  = r_rspZero;
  assign rsp_id    = r_rspId;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same requests and
// checks both against a transaction-level model every cycle.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0Valid, req1Valid, rspReady;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic [3:0]  req0Op, req1Op;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  wire  [1:0]  ready0, ready1, rspValid, rspZero, rspId, rspErr;
  wire  [31:0] rspData0, rspData1;

  int nChecks = 0;
  int nFails  = 0;

  bit          mValid [2];
  logic [31:0] mData  [2];
  bit          mZero  [2];
  bit          mId    [2];
  bit          mErr   [2];
  bit          mLast  [2];

  alu_arbiter #(.FIXED_PRI(1'b0)) dutRr (
    .clk(clk), .reset(reset),
    .req0_valid(req0Valid), .req0_ready(ready0[0]), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
    .req1_valid(req1Valid), .req1_ready(ready1[0]), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady), .rsp_data(rspData0),
    .rsp_zero(rspZero[0]), .rsp_id(rspId[0]), .rsp_err(rspErr[0])
  );

  alu_arbiter #(.FIXED_PRI(1'b1)) dutFp (
    .clk(clk), .reset(reset),
    .req0_valid(req0Valid), .req0_ready(ready0[1]), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
    .req1_valid(req1Valid), .req1_ready(ready1[1]), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady), .rsp_data(rspData1),
    .rsp_zero(rspZero[1]), .rsp_id(rspId[1]), .rsp_err(rspErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the ALU must produce, written straight from the op table.
  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legalModel(input logic [3:0] op);
    return op == 4'b0010 || op == 4'b0110 || op == 4'b0000 || op == 4'b0001 || op == 4'b0111;
  endfunction

  // Winner when someone is valid: lone requester, else priority or "not the last one served".
  function automatic bit modelGrant(input int d);
    if (req0Valid && req1Valid) return (d == 1) ? 1'b0 : !mLast[d];
    return req1Valid;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                               input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                               input bit rr);
    req0Valid = v0; req0A = a0; req0B = b0; req0Op = op0;
    req1Valid = v1; req1A = a1; req1B = b1; req1Op = op1;
    rspReady  = rr;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  // Reference model: one accepted transaction per edge, result held until drained.
  always @(posedge clk or posedge reset) begin
    bit g, acc;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mValid[d] = 1'b0; mData[d] = 32'd0; mZero[d] = 1'b0;
        mId[d] = 1'b0; mErr[d] = 1'b0; mLast[d] = 1'b1;
      end else begin
        acc = !mValid[d] || rspReady;
        if ((req0Valid || req1Valid) && acc) begin
          g = modelGrant(d);
          mData[d]  = g ? aluModel(req1Op, req1A, req1B) : aluModel(req0Op, req0A, req0B);
          mErr[d]   = g ? !legalModel(req1Op) : !legalModel(req0Op);
          mZero[d]  = (mData[d] == 32'd0);
          mId[d]    = g;
          mLast[d]  = g;
          mValid[d] = 1'b1;
        end else if (mValid[d] && rspReady) begin
          mValid[d] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit acc, g;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        acc = !mValid[d] || rspReady;
        g   = modelGrant(d);
        checkOutput($sformatf("dut%0d rsp_valid", d), rspValid[d], mValid[d]);
        checkOutput($sformatf("dut%0d req0_ready", d), ready0[d], acc && req0Valid && !g);
        checkOutput($sformatf("dut%0d req1_ready", d), ready1[d], acc && req1Valid && g);
        if (mValid[d]) begin
          checkOutput($sformatf("dut%0d rsp_data", d), (d == 0) ? rspData0 : rspData1, mData[d]);
          checkOutput($sformatf("dut%0d rsp_zero", d), rspZero[d], mZero[d]);
          checkOutput($sformatf("dut%0d rsp_id", d), rspId[d], mId[d]);
          checkOutput($sformatf("dut%0d rsp_err", d), rspErr[d], mErr[d]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req0Valid = 0; req0A = 0; req0B = 0; req0Op = 0;
    req1Valid = 0; req1A = 0; req1B = 0; req1Op = 0;
    rspReady = 0;
    #1;
    checkOutput("reset rsp_valid", rspValid, 2'b00);
    checkOutput("reset rsp_data", rspData0, 32'd0);
    checkOutput("reset flags", {rspZero, rspId, rspErr}, 6'd0);
    @(posedge clk); #2;
    stepCycle();
    reset = 1'b0;

    // Single add from requester 0.
    applyStimulus(1, 32'd5, 32'd7, 4'b0010, 0, 0, 0, 4'b0, 1);
    checkOutput("add req0_ready", ready0[0], 1'b1);
    stepCycle();
    checkOutput("add rsp_valid", rspValid[0], 1'b1);
    checkOutput("add rsp_data", rspData0, 32'd12);
    checkOutput("add rsp_id", rspId[0], 1'b0);
    checkOutput("add zero/err", {rspZero[0], rspErr[0]}, 2'b00);

    // Both valid every cycle: round-robin alternates, fixed priority sticks on 0.
    applyStimulus(0, 0, 0, 4'b0, 0, 0, 0, 4'b0, 1);
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'd3, 32'd3, 4'b0110, 1, 32'd10, 32'd20, 4'b0010, 1);
      checkOutput($sformatf("fp req1_ready c%0d", i), ready1[1], 1'b0);
      stepCycle();
      checkOutput($sformatf("rr rsp_id c%0d", i), rspId[0], i % 2);
      checkOutput($sformatf("rr rsp_data c%0d", i), rspData0, (i % 2) ? 32'd30 : 32'd0);
      checkOutput($sformatf("rr rsp_zero c%0d", i), rspZero[0], (i % 2) ? 1'b0 : 1'b1);
      checkOutput($sformatf("fp rsp_id c%0d", i), rspId[1], 1'b0);
      checkOutput($sformatf("fp rsp_zero c%0d", i), rspZero[1], 1'b1);
    end

    // Consumer stalls: result holds and requester 1 is kept waiting.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'b0, 1, 32'd100, 32'd1, 4'b0010, 0);
      checkOutput($sformatf("stall req1_ready c%0d", i), ready1[0], 1'b0);
      stepCycle();
      checkOutput($sformatf("stall rsp_data c%0d", i), rspData0, 32'd30);
      checkOutput($sformatf("stall rsp_valid c%0d", i), rspValid[0], 1'b1);
    end
    applyStimulus(0, 0, 0, 4'b0, 1, 32'd100, 32'd1, 4'b0010, 1);
    checkOutput("unstall req1_ready", ready1[0], 1'b1);
    stepCycle();
    checkOutput("unstall rsp_data", rspData0, 32'd101);
    checkOutput("unstall rsp_id", rspId[0], 1'b1);

    // Illegal op and unsigned set-less-than.
    applyStimulus(0, 0, 0, 4'b0, 1, 32'd5, 32'd6, 4'b1111, 1);
    stepCycle();
    checkOutput("illegal err/zero", {rspErr[0], rspZero[0]}, 2'b11);
    checkOutput("illegal data", rspData0, 32'd0);
    applyStimulus(0, 0, 0, 4'b0, 1, 32'hFFFF_FFFF, 32'd1, 4'b0111, 1);
    stepCycle();
    checkOutput("slt big<1 data", rspData0, 32'd0);
    checkOutput("slt big<1 err", rspErr[0], 1'b0);
    applyStimulus(0, 0, 0, 4'b0, 1, 32'd1, 32'hFFFF_FFFF, 4'b0111, 1);
    stepCycle();
    checkOutput("slt 1<big data", rspData0, 32'd1);

    // Reset while holding a result.
    applyStimulus(0, 0, 0, 4'b0, 0, 0, 0, 4'b0, 0);
    stepCycle();
    checkOutput("pre-reset rsp_valid", rspValid, 2'b11);
    reset = 1'b1;
    req0Valid = 1'b1;
    #1;
    checkOutput("async reset rsp_valid", rspValid, 2'b00);
    checkOutput("async reset rsp_data", rspData0, 32'd0);
    checkOutput("reset req0_ready", ready0, 2'b00);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1, 32'd1, 32'd2, 4'b0001, 1, 32'd4, 32'd8, 4'b0001, 1);
    stepCycle();
    checkOutput("post-reset rr rsp_id", rspId[0], 1'b0);
    checkOutput("post-reset rr rsp_data", rspData0, 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ops [6];
      ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0000;
      ops[3] = 4'b0001; ops[4] = 4'b0111; ops[5] = 4'($urandom);
      applyStimulus($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, ops[$urandom_range(0, 5)],
                    $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ops[$urandom_range(0, 5)], $urandom_range(0, 3) != 0);
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRI, default 0, 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 ALU control code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result register holds an unconsumed result.
REQ-010 rsp_ready  input  1  consumer accepts result this cycle.
REQ-011 rsp_data  output  32  ALU result.
REQ-012 rsp_zero  output  1  rsp_data == 0.
REQ-013 rsp_id  output  1  requester that issued the result.
REQ-014 rsp_err  output  1  issued op code not in legal set.

Function
REQ-015 Legal ops SHALL be 0010 add, 0110 sub, 0000 and, 0001 or, 0111 unsigned set-less-than (1 if a<b else 0); any other code SHALL yield rsp_data 0, rsp_zero 1, rsp_err 1.
REQ-016 Arithmetic SHALL be 32-bit, modulo 2^32, carry/borrow discarded.
REQ-017 Two states: EMPTY (rsp_valid 0), FULL (rsp_valid 1).
REQ-018 can_accept SHALL be (EMPTY) or (FULL and rsp_ready), combinational.
REQ-019 Transfer on requester i occurs when req_i_valid, req_i_ready both 1 at a rising edge; reqN_ready SHALL be can_accept and grant==N, never both 1.
REQ-020 Grant: only one valid -> that one; both valid, FIXED_PRI=1 -> requester 0; both valid, FIXED_PRI=0 -> requester not most recently transferred.
REQ-021 Round-robin pointer SHALL update only on a transfer, never on valid without ready.
REQ-022 Latency: transfer at edge N -> rsp_valid 1 with rsp_data/zero/id/err registered at edge N; throughput one result per cycle while rsp_ready held 1.
REQ-023 FULL with rsp_ready 0: outputs SHALL hold stable, both ready 0.
REQ-024 FULL, rsp_ready 1, no request valid -> EMPTY next edge; with a request -> stay FULL with new result (back-to-back).
REQ-025 EMPTY with no valid request: no state change.
REQ-026 Requesters SHALL hold valid and operands stable until ready; block does not latch unaccepted requests.

Reset
REQ-027 Reset SHALL force EMPTY, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_id 0, rsp_err 0, RR pointer to favour requester 0.
REQ-028 Reset mid-operation SHALL discard a held result; no transfer SHALL occur while reset is high.

Structure
REQ-029 Shared package SHALL hold the 4-bit ALU op constants (ADD, SUB, AND, OR, SLT) and the EMPTY/FULL state encoding.
REQ-030 The ALU SHALL be the existing combinational alu sub-module, one instance, fed by the granted operands/op mux; rsp_err decode lives in alu_arbiter.

Verification
REQ-031 Reset release, req0 add a=5 b=7, rsp_ready 1 -> next cycle rsp_valid 1, data 12, id 0, zero 0, err 0.
REQ-032 Both valid every cycle, FIXED_PRI 0, rsp_ready 1 -> grants alternate 0,1,0,1; req0 sub 3-3 gives data 0 zero 1.
REQ-033 Same as 032 with FIXED_PRI 1 -> requester 0 granted every cycle, req1_ready stays 0.
REQ-034 Result held with rsp_ready 0 for 4 cycles, req1 valid -> rsp_data stable, req1_ready 0; rsp_ready 1 -> req1 transferred same cycle, new result next cycle.
REQ-035 req1 op 1111, slt a=0xFFFFFFFF b=1 -> err 1 data 0; slt gives data 0 (unsigned).
REQ-036 Assert reset while FULL -> rsp_valid 0 immediately, RR pointer favours requester 0 after release.
